// File: rtl/cache_def.sv
// Shared cache definitions: CPU request/result records plus arbiter state and
// requester count used by cache_port_arbiter.
package cache_def;

  localparam int TAGMSB   = 31;
  localparam int LINE_W   = 128;
  localparam int ARB_REQS = 2;

  typedef struct packed {
    logic              valid;
    logic              rw;
    logic [TAGMSB:0]   addr;
    logic [LINE_W-1:0] data;
  } cpu_req_type;

  typedef struct packed {
    logic              ready;
    logic              checked;
    logic [LINE_W-1:0] data;
  } cpu_result_type;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_RESP
  } arb_state_type;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// requester that was not granted last.
module arb_rr_pick
  import cache_def::*;
(
  input  logic [ARB_REQS-1:0] valid,
  input  logic                last,
  output logic [ARB_REQS-1:0] grant
);

  always_comb begin
    // NOTE: default assignment first so no path leaves grant unassigned (no latch).
    grant = '0;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Two-port front end for the blocking cache FSM: one transaction in flight,
// round-robin grant. Define CACHE_ARB_STATS_EN for grant/miss counters.
module cache_port_arbiter
  import cache_def::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_rw,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_done,
  input  logic              req1_valid,
  input  logic              req1_rw,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_done,
  output logic [DATA_W-1:0] rdata,
`ifdef CACHE_ARB_STATS_EN
  output logic [31:0]       grant_cnt0,
  output logic [31:0]       grant_cnt1,
  output logic [31:0]       miss_cnt,
`endif
  output cpu_req_type       cache_req,
  input  cpu_result_type    cache_res
);

  arb_state_type       state, state_nxt;
  logic [ARB_REQS-1:0] grant;
  logic                accept;
  logic                last_q;
  logic                owner_q;
  logic                rw_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                unused_checked;

  assign unused_checked = cache_res.checked;

  arb_rr_pick u_pick (
    .valid ({req1_valid, req0_valid}),
    .last  (last_q),
    .grant (grant)
  );

  assign accept = (state == ARB_IDLE) && (grant != '0);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (accept)          state_nxt = ARB_BUSY;
      ARB_BUSY: if (cache_res.ready) state_nxt = ARB_RESP;
      ARB_RESP:                      state_nxt = ARB_IDLE;
      default:                       state_nxt = ARB_IDLE;
    endcase
  end

  // Payload is presented only in BUSY so the cache never re-arms on a finished request.
  always_comb begin
    cache_req  = '0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    req0_done  = 1'b0;
    req1_done  = 1'b0;
    case (state)
      ARB_IDLE: begin
        req0_ready = grant[0] & ~rst;
        req1_ready = grant[1] & ~rst;
      end
      ARB_BUSY: begin
        cache_req.valid = 1'b1;
        cache_req.rw    = rw_q;
        cache_req.addr  = addr_q;
        cache_req.data  = wdata_q;
      end
      ARB_RESP: begin
        req0_done = ~owner_q;
        req1_done = owner_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      if (accept) begin
        last_q  <= grant[1];
        owner_q <= grant[1];
        rw_q    <= grant[1] ? req1_rw    : req0_rw;
        addr_q  <= grant[1] ? req1_addr  : req0_addr;
        wdata_q <= grant[1] ? req1_wdata : req0_wdata;
      end
      if (state == ARB_BUSY && cache_res.ready) rdata <= cache_res.data;
    end
  end

`ifdef CACHE_ARB_STATS_EN
  logic [31:0] grant_cnt0_q, grant_cnt1_q, miss_cnt_q;
  logic [1:0]  busy_len;   // BUSY cycles before the current one, saturating at 2

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
      miss_cnt_q   <= '0;
      busy_len     <= '0;
    end else begin
      if (accept) begin
        busy_len <= '0;
        if (grant[0]) grant_cnt0_q <= sat_inc(grant_cnt0_q);
        if (grant[1]) grant_cnt1_q <= sat_inc(grant_cnt1_q);
      end
      if (state == ARB_BUSY) begin
        if (cache_res.ready) begin
          busy_len <= '0;
          if (busy_len == 2'd2) miss_cnt_q <= sat_inc(miss_cnt_q);
        end else if (busy_len != 2'd2) begin
          busy_len <= busy_len + 2'd1;
        end
      end
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
  assign miss_cnt   = miss_cnt_q;
`endif

endmodule

// File: doc/cache_port_arbiter.md
CACHE_PORT_ARBITER -- requirements
Module: cache_port_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width; equals TAGMSB+1 of cache_def.
REQ-002 Parameter DATA_W, 128, cache line / request data width.
REQ-003 Port clk  in  1  single clock; all state on posedge clk.
REQ-004 Port rst  in  1  reset, asynchronous and active-high.
REQ-005 Ports req0_valid/req1_valid  in  1  requester N presents a request.
REQ-006 Ports req0_rw/req1_rw  in  1  1=write, 0=read.
REQ-007 Ports req0_addr/req1_addr  in  ADDR_W  request address.
REQ-008 Ports req0_wdata/req1_wdata  in  DATA_W  write data.
REQ-009 Ports req0_ready/req1_ready  out  1  request accepted this cycle (valid&ready).
REQ-010 Ports req0_done/req1_done  out  1  one-cycle completion pulse.
REQ-011 Port rdata  out  DATA_W  line data, valid while any reqN_done=1.
REQ-012 Port cache_req  out  cpu_req_type  {valid, rw, addr, data} to the cache FSM.
REQ-013 Port cache_res  in  cpu_result_type  {ready, checked, data} from the cache FSM.

Function
REQ-014 FSM states: ARB_IDLE, ARB_BUSY, ARB_RESP; one transaction in flight at most.
REQ-015 ARB_IDLE: reqN_ready combinational = grant to N; ready=0 for both in BUSY/RESP.
REQ-016 Grant: single requester valid wins; both valid -> requester not granted last (round-robin); last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-017 On accept: latch rw/addr/wdata and owner ID, update pointer, go ARB_BUSY next cycle.
REQ-018 ARB_BUSY: cache_req.valid=1 with latched payload held stable every cycle; payload never changes in BUSY.
REQ-019 ARB_BUSY and cache_res.ready=1: register cache_res.data into rdata, go ARB_RESP.
REQ-020 ARB_RESP: cache_req.valid=0; owner's reqN_done=1 for exactly one cycle; next state ARB_IDLE.
REQ-021 cache_req.valid is never 1 in ARB_IDLE or ARB_RESP, so the cache FSM never re-arms on a finished request.
REQ-022 Latency for a cache hit: accept cycle T, done at T+3; misses extend BUSY only.
REQ-023 Requester valid dropped before accept -> no transaction; inputs ignored after accept.
REQ-024 rdata holds last value outside RESP; write transactions also capture cache_res.data.

Reset
REQ-025 rst=1 immediately forces ARB_IDLE, cache_req='0, reqN_ready=0, reqN_done=0, rdata='0, pointer=1.
REQ-026 Reset mid-BUSY abandons the transaction with no done pulse; the cache FSM shares rst.

Configuration
REQ-027 Macro CACHE_ARB_STATS_EN defined: outputs grant_cnt0, grant_cnt1, miss_cnt (32 bit each, saturating at 32'hFFFFFFFF, reset 0).
REQ-028 grant_cntN +1 per accept by N; miss_cnt +1 per transaction whose BUSY phase exceeds 2 cycles.
REQ-029 Macro undefined: the three ports and counters do not exist; all other behaviour identical.

Structure
REQ-030 cache_def package gains arb_state_type enum and constant ARB_REQS=2; cpu_req_type/cpu_result_type are reused unchanged.
REQ-031 Grant logic is sub-module arb_rr_pick (inputs valid[1:0], last; outputs grant[1:0]), purely combinational.

Verification
REQ-032 req0 read 0x0000_0040, cache hit -> req0_ready at T, cache_req.valid T+1..T+2, req0_done and rdata=line at T+3.
REQ-033 req0 and req1 valid at the same cycle after reset -> req0 granted first, req1 granted in the first IDLE after req0_done.
REQ-034 Both valid continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
REQ-035 req1 write miss with dirty victim (BUSY lasts 8 cycles) -> addr/data stable all 8 cycles, single req1_done, miss_cnt=1 with CACHE_ARB_STATS_EN.
REQ-036 rst asserted in BUSY cycle 2 -> cache_req.valid=0 the same cycle, no done pulse, next request accepted after release.
REQ-037 Preload grant_cnt0 to 32'hFFFFFFFF via force, one more grant -> value stays 32'hFFFFFFFF.
